// File: rtl/shift_reg_sequencer_if.sv
// Byte-in / bit-out handshake bundle between a producer and shift_reg_sequencer.
// master = producer/consumer side (the bench or upstream logic), slave = the sequencer.
interface shift_reg_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       lsb_first;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       ser_ready;

    modport master (
        output in_data, in_valid, lsb_first, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last
    );

    modport slave (
        input  in_data, in_valid, lsb_first, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Sequencer for an 8-bit load/shift register: loads accepted bytes, streams q out bit-serially.
// Optional parity bit after the data bits when SHIFT_REG_SEQUENCER_PARITY_EN is defined.
//
//   state  | meaning
//   IDLE   | ready for a byte; register held by reloading q
//   SHIFT  | presenting data bit r_count; shift on handshake
//   PARITY | presenting parity bit (parity build only); register held
module shift_reg_sequencer #(
    parameter int BIT_CNT    = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    shift_reg_sequencer_if.slave  bus,
    input  logic [7:0]            sr_q,
    output logic [7:0]            sr_i,
    output logic                  sr_load_enable,
    output logic                  sr_shift_left_right,
    output logic                  busy
);

`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
    localparam int   CNT_W   = 4;
    localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
    localparam int CNT_W = 3;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CNT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               w_is_last;
    logic               w_data_bit;
    logic [CNT_W-1:0]   w_count_inc;

`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
    logic               r_par;
    logic               w_par_nxt;
`else
    logic               w_unused_cfg;
    assign w_unused_cfg = (PARITY_ODD != 0);
`endif

    assign w_is_last   = (r_count == LAST_CNT);
    assign w_data_bit  = r_dir ? sr_q[0] : sr_q[7];
    assign w_count_inc = r_count + CNT_W'(1);
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_dir   <= 1'b0;
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // The register has no hold mode: every non-shift cycle reloads q into i.
    always_comb begin
        w_state_nxt         = r_state;
        w_count_nxt         = r_count;
        w_dir_nxt           = r_dir;
        sr_i                = sr_q;
        sr_load_enable      = 1'b0;
        sr_shift_left_right = 1'b0;
        bus.in_ready        = 1'b0;
        bus.ser_valid       = 1'b0;
        bus.ser_last        = 1'b0;
        bus.ser_out         = 1'b0;
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
        w_par_nxt           = r_par;
`endif
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    sr_i        = bus.in_data;
                    w_dir_nxt   = bus.lsb_first;
                    w_count_nxt = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bus.ser_valid       = 1'b1;
                bus.ser_out         = w_data_bit;
                sr_shift_left_right = r_dir;
`ifndef SHIFT_REG_SEQUENCER_PARITY_EN
                bus.ser_last        = w_is_last;
`endif
                if (bus.ser_ready) begin
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
                    w_par_nxt = r_par ^ w_data_bit;
`endif
                    if (!w_is_last) begin
                        sr_load_enable = 1'b1;
                        w_count_nxt    = w_count_inc;
                    end else begin
                        w_count_nxt = '0;
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
            PARITY: begin
                bus.ser_valid = 1'b1;
                bus.ser_last  = 1'b1;
                bus.ser_out   = r_par ^ PAR_ODD;
                if (bus.ser_ready) begin
                    w_par_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: two instances (BIT_CNT 8 and 4), each with a model of the
// attached shift register and a bit-queue model of the expected serial stream.
module tb_shift_reg_sequencer;
    localparam int TB_PAR_ODD = 0;
`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
    localparam int PL = 1;
`else
    localparam int PL = 0;
`endif
    localparam int NB0 = 8;
    localparam int NB1 = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    shift_reg_sequencer_if bus0 ();
    shift_reg_sequencer_if bus1 ();

    logic [1:0][7:0] in_data_a;
    logic [1:0][7:0] sr_q_a;
    logic [1:0][7:0] sr_i_a;
    logic [1:0] in_valid_a, lsb_a, rdy_a;
    logic [1:0] in_ready_a, ser_out_a, ser_valid_a, ser_last_a, le_a, lr_a, busy_a;

    assign bus0.in_data   = in_data_a[0];
    assign bus0.in_valid  = in_valid_a[0];
    assign bus0.lsb_first = lsb_a[0];
    assign bus0.ser_ready = rdy_a[0];
    assign bus1.in_data   = in_data_a[1];
    assign bus1.in_valid  = in_valid_a[1];
    assign bus1.lsb_first = lsb_a[1];
    assign bus1.ser_ready = rdy_a[1];
    assign in_ready_a  = {bus1.in_ready,  bus0.in_ready};
    assign ser_out_a   = {bus1.ser_out,   bus0.ser_out};
    assign ser_valid_a = {bus1.ser_valid, bus0.ser_valid};
    assign ser_last_a  = {bus1.ser_last,  bus0.ser_last};

    shift_reg_sequencer #(.BIT_CNT(NB0), .PARITY_ODD(TB_PAR_ODD)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .sr_q(sr_q_a[0]), .sr_i(sr_i_a[0]), .sr_load_enable(le_a[0]),
        .sr_shift_left_right(lr_a[0]), .busy(busy_a[0])
    );

    shift_reg_sequencer #(.BIT_CNT(NB1), .PARITY_ODD(TB_PAR_ODD)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .sr_q(sr_q_a[1]), .sr_i(sr_i_a[1]), .sr_load_enable(le_a[1]),
        .sr_shift_left_right(lr_a[1]), .busy(busy_a[1])
    );

    // Attached register: load when load_enable = 0, else shift (0 = left, 1 = right).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q_a <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!le_a[ch])      sr_q_a[ch] <= sr_i_a[ch];
                else if (lr_a[ch])  sr_q_a[ch] <= {1'b0, sr_q_a[ch][7:1]};
                else                sr_q_a[ch] <= {sr_q_a[ch][6:0], 1'b0};
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d actual=%0h expected=%0h t=%0t", name, ch, act, exp, $time);
        end
    endtask

    // Stream model: the whole frame is queued as bits at accept, popped on each handshake.
    bit exp_q[2][$];
    bit exp_dir[2];

    function automatic int nbits(input int ch);
        return (ch == 0) ? NB0 : NB1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                exp_q[ch].delete();
                exp_dir[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (exp_q[ch].size() != 0) begin
                    if (rdy_a[ch]) void'(exp_q[ch].pop_front());
                end else if (in_valid_a[ch]) begin
                    bit par;
                    bit b;
                    par = 1'b0;
                    exp_dir[ch] = lsb_a[ch];
                    for (int k = 0; k < nbits(ch); k++) begin
                        b = lsb_a[ch] ? in_data_a[ch][k] : in_data_a[ch][7-k];
                        par ^= b;
                        exp_q[ch].push_back(b);
                    end
                    if (PL == 1) exp_q[ch].push_back(par ^ (TB_PAR_ODD != 0));
                end
            end
        end
    end

    logic [15:0] cap[2];
    int capn[2];
    int lastn[2];

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (!reset_n) begin
                chk("rst_ser_valid", ch, 32'(ser_valid_a[ch]), 32'd0);
                chk("rst_in_ready",  ch, 32'(in_ready_a[ch]),  32'd1);
                chk("rst_busy",      ch, 32'(busy_a[ch]),      32'd0);
                chk("rst_sr_q",      ch, 32'(sr_q_a[ch]),      32'd0);
            end else begin
                int sz;
                int dl;
                bit shifting;
                sz = exp_q[ch].size();
                chk("ser_valid", ch, 32'(ser_valid_a[ch]), 32'(sz != 0));
                chk("in_ready",  ch, 32'(in_ready_a[ch]),  32'(sz == 0));
                chk("busy",      ch, 32'(busy_a[ch]),      32'(sz != 0));
                if (sz != 0) begin
                    dl = sz - PL;
                    shifting = rdy_a[ch] && (dl > 1);
                    chk("ser_out",  ch, 32'(ser_out_a[ch]),  32'(exp_q[ch][0]));
                    chk("ser_last", ch, 32'(ser_last_a[ch]), 32'(sz == 1));
                    chk("load_en",  ch, 32'(le_a[ch]),       32'(shifting));
                    if (dl > 0) chk("shift_dir", ch, 32'(lr_a[ch]), 32'(exp_dir[ch]));
                    if (!shifting) chk("hold_sr_i", ch, 32'(sr_i_a[ch]), 32'(sr_q_a[ch]));
                end else begin
                    chk("idle_load_en", ch, 32'(le_a[ch]), 32'd0);
                    chk("idle_dir",     ch, 32'(lr_a[ch]), 32'd0);
                    chk("idle_sr_i",    ch, 32'(sr_i_a[ch]),
                        32'(in_valid_a[ch] ? in_data_a[ch] : sr_q_a[ch]));
                end
                if (ser_valid_a[ch] && rdy_a[ch]) begin
                    cap[ch] = {cap[ch][14:0], ser_out_a[ch]};
                    capn[ch]++;
                    if (ser_last_a[ch]) lastn[ch]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap(input int ch);
        cap[ch] = '0;
        capn[ch] = 0;
        lastn[ch] = 0;
    endtask

    function automatic logic [7:0] data_bits(input int ch);
        logic [15:0] v;
        v = cap[ch] >> PL;
        return v[7:0];
    endfunction

    task automatic send(input int ch, input logic [7:0] d, input logic lsb);
        in_data_a[ch] = d;
        lsb_a[ch] = lsb;
        in_valid_a[ch] = 1'b1;
        tick();
        in_valid_a[ch] = 1'b0;
    endtask

    task automatic wait_done(input int ch);
        int n;
        n = 0;
        while (exp_q[ch].size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("frame_timeout", ch, 32'(exp_q[ch].size()), 32'd0);
    endtask

    task automatic wait_capn(input int ch, input int target);
        int n;
        n = 0;
        while (capn[ch] < target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("capture_timeout", ch, 32'(capn[ch]), 32'(target));
    endtask

    typedef struct { logic [7:0] d; logic lsb; logic [7:0] stream; } vec_t;
    vec_t vecs[4];
    logic [7:0] snap;

    initial begin
        in_data_a = '0; in_valid_a = '0; lsb_a = '0; rdy_a = 2'b11;
        clear_cap(0); clear_cap(1);
        vecs[0] = '{8'h3C, 1'b0, 8'h3C};
        vecs[1] = '{8'h81, 1'b1, 8'h81};
        vecs[2] = '{8'h6B, 1'b1, 8'hD6};
        vecs[3] = '{8'h12, 1'b1, 8'h48};

        repeat (3) tick();
        chk("reset_in_ready",  0, 32'(in_ready_a[0]),  32'd1);
        chk("reset_ser_valid", 0, 32'(ser_valid_a[0]), 32'd0);
        chk("reset_ser_last",  0, 32'(ser_last_a[0]),  32'd0);
        chk("reset_ser_out",   0, 32'(ser_out_a[0]),   32'd0);
        chk("reset_sr_i",      0, 32'(sr_i_a[0]),      32'd0);
        chk("reset_load_en",   0, 32'(le_a[0]),        32'd0);
        reset_n = 1'b1;
        tick();

        // A5 MSB-first
        clear_cap(0);
        send(0, 8'hA5, 1'b0);
        wait_done(0);
        chk("a5_msb_stream", 0, 32'(data_bits(0)), 32'hA5);
        chk("a5_msb_count",  0, 32'(capn[0]),      32'(8 + PL));
        chk("a5_msb_last",   0, 32'(lastn[0]),     32'd1);
        chk("a5_in_ready",   0, 32'(in_ready_a[0]), 32'd1);

        // A5 LSB-first
        clear_cap(0);
        send(0, 8'hA5, 1'b1);
        wait_done(0);
        chk("a5_lsb_stream", 0, 32'(data_bits(0)), 32'hA5);
        chk("a5_lsb_last",   0, 32'(lastn[0]),     32'd1);

        // C3 MSB-first with a 3-cycle stall on bit 2
        clear_cap(0);
        send(0, 8'hC3, 1'b0);
        wait_capn(0, 2);
        rdy_a[0] = 1'b0;
        snap = sr_q_a[0];
        repeat (3) begin
            tick();
            chk("stall_sr_q",    0, 32'(sr_q_a[0]),    32'(snap));
            chk("stall_ser_out", 0, 32'(ser_out_a[0]), 32'd0);
            chk("stall_load_en", 0, 32'(le_a[0]),      32'd0);
        end
        rdy_a[0] = 1'b1;
        wait_done(0);
        chk("c3_stream", 0, 32'(data_bits(0)), 32'hC3);
        chk("c3_count",  0, 32'(capn[0]),      32'(8 + PL));

        // Reset after bit 4 of FF, then 01
        clear_cap(0);
        send(0, 8'hFF, 1'b0);
        wait_capn(0, 4);
        reset_n = 1'b0;
        #1;
        chk("midrst_ser_valid", 0, 32'(ser_valid_a[0]), 32'd0);
        chk("midrst_in_ready",  0, 32'(in_ready_a[0]),  32'd1);
        chk("midrst_sr_q",      0, 32'(sr_q_a[0]),      32'd0);
        chk("midrst_no_last",   0, 32'(lastn[0]),       32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        clear_cap(0);
        send(0, 8'h01, 1'b0);
        wait_done(0);
        chk("post_rst_stream", 0, 32'(data_bits(0)), 32'h01);
        chk("post_rst_last",   0, 32'(lastn[0]),     32'd1);

        // BIT_CNT = 4 with in_valid held through the frame
        clear_cap(1);
        in_data_a[1] = 8'h9F;
        lsb_a[1] = 1'b0;
        in_valid_a[1] = 1'b1;
        wait_capn(1, 4 + PL);
        chk("bc4_stream", 1, 32'(data_bits(1) & 8'h0F), 32'h9);
        chk("bc4_last",   1, 32'(lastn[1]),             32'd1);
        clear_cap(1);
        in_data_a[1] = 8'h5A;
        tick();
        in_valid_a[1] = 1'b0;
        wait_done(1);
        chk("bc4_second_stream", 1, 32'(data_bits(1) & 8'h0F), 32'h5);
        chk("bc4_second_count",  1, 32'(capn[1]),              32'(4 + PL));

        // Irregular ready pattern
        foreach (vecs[i]) begin
            int n;
            clear_cap(0);
            send(0, vecs[i].d, vecs[i].lsb);
            n = 0;
            while (exp_q[0].size() != 0 && n < 100) begin
                rdy_a[0] = ((n % 3) != 1);
                tick();
                n++;
            end
            rdy_a[0] = 1'b1;
            if (n >= 100) chk("vec_timeout", 0, 32'(exp_q[0].size()), 32'd0);
            chk("vec_stream", 0, 32'(data_bits(0)), 32'(vecs[i].stream));
            chk("vec_last",   0, 32'(lastn[0]),     32'd1);
        end

`ifdef SHIFT_REG_SEQUENCER_PARITY_EN
        clear_cap(0);
        send(0, 8'h07, 1'b0);
        wait_done(0);
        chk("par_data",  0, 32'(data_bits(0)), 32'h07);
        chk("par_bit",   0, 32'(cap[0][0]),    (TB_PAR_ODD != 0) ? 32'd0 : 32'd1);
        chk("par_count", 0, 32'(capn[0]),      32'd9);
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
